// File: rtl/banked_cache_block_if.sv
// CPU word-port and line-burst signal bundle for banked_cache_block.
interface banked_cache_block_if #(
  parameter int WORD_WIDTH = 32,
  parameter int BANKS      = 4,
  parameter int DEPTH      = 256
);
  localparam int BYTES = WORD_WIDTH / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BANKS);

  logic                  port0_write_i;
  logic [AW-1:0]         port0_address_i;
  logic [BW-1:0]         port0_bank_i;
  logic [BYTES-1:0]      port0_byte_write_i;
  logic [WORD_WIDTH-1:0] port0_data_i;
  logic                  port1_read_i;
  logic [AW-1:0]         port1_address_i;
  logic [BW-1:0]         port1_bank_i;
  logic [WORD_WIDTH-1:0] port1_data_o;
  logic                  port1_valid_o;
  logic                  burst_start_i;
  logic                  burst_refill_i;
  logic [AW-1:0]         burst_address_i;
  logic [WORD_WIDTH-1:0] burst_data_i;
  logic                  burst_data_valid_i;
  logic [WORD_WIDTH-1:0] burst_data_o;
  logic                  burst_data_valid_o;
  logic                  burst_busy_o;
  logic                  burst_done_o;

  modport master (
    output port0_write_i, port0_address_i, port0_bank_i, port0_byte_write_i, port0_data_i,
    output port1_read_i, port1_address_i, port1_bank_i,
    input  port1_data_o, port1_valid_o,
    output burst_start_i, burst_refill_i, burst_address_i, burst_data_i, burst_data_valid_i,
    input  burst_data_o, burst_data_valid_o, burst_busy_o, burst_done_o
  );

  modport slave (
    input  port0_write_i, port0_address_i, port0_bank_i, port0_byte_write_i, port0_data_i,
    input  port1_read_i, port1_address_i, port1_bank_i,
    output port1_data_o, port1_valid_o,
    input  burst_start_i, burst_refill_i, burst_address_i, burst_data_i, burst_data_valid_i,
    output burst_data_o, burst_data_valid_o, burst_busy_o, burst_done_o
  );
endinterface

// File: rtl/banked_cache_block.sv
// Banked cache line store: byte-masked CPU write, 1-cycle CPU read with same-cycle
// forwarding, and a refill/writeback line sequencer that locks out the CPU while busy.
module banked_cache_block #(
  parameter int WORD_WIDTH = 32,
  parameter int BANKS      = 4,
  parameter int DEPTH      = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  banked_cache_block_if.slave bus
);
  localparam int BYTES = WORD_WIDTH / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BANKS);
  localparam logic [BW-1:0] LAST = BW'(BANKS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITEBACK, DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [BW-1:0]         r_cnt, w_cnt_nxt;
  logic [AW-1:0]         r_addr;
  logic                  r_done, w_done_nxt;
  logic                  w_fill_we;
  logic                  r_rd_vld, r_wb_vld;
  logic [WORD_WIDTH-1:0] r_rd_dat, r_wb_dat;
  logic [WORD_WIDTH-1:0] r_mem [DEPTH*BANKS];

  logic                  w_idle, w_cpu_we, w_cpu_re, w_fwd;
  logic [WORD_WIDTH-1:0] w_rd_old, w_rd_word, w_wb_word;

  assign w_idle    = (r_state == IDLE);
  assign w_cpu_we  = w_idle & bus.port0_write_i;
  assign w_cpu_re  = w_idle & bus.port1_read_i;
  assign w_fwd     = w_cpu_we & (bus.port0_address_i == bus.port1_address_i)
                              & (bus.port0_bank_i == bus.port1_bank_i);
  assign w_rd_old  = r_mem[{bus.port1_address_i, bus.port1_bank_i}];
  assign w_wb_word = r_mem[{r_addr, r_cnt}];

  // Same-word write in the read cycle: enabled bytes come from the write data.
  always_comb begin
    w_rd_word = w_rd_old;
    for (int b = 0; b < BYTES; b++) begin
      if (w_fwd && bus.port0_byte_write_i[b]) begin
        w_rd_word[b*8 +: 8] = bus.port0_data_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_fill_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.burst_start_i) begin
          w_state_nxt = bus.burst_refill_i ? REFILL : WRITEBACK;
          w_cnt_nxt   = '0;
        end
      end
      REFILL: begin
        if (bus.burst_data_valid_i) begin
          w_fill_we = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // Done is raised entering DRAIN so it lines up with the last word out.
        if (r_cnt == LAST) begin
          w_state_nxt = DRAIN;
          w_done_nxt  = 1'b1;
        end
      end
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_addr   <= '0;
      r_rd_vld <= 1'b0;
      r_rd_dat <= '0;
      r_wb_vld <= 1'b0;
      r_wb_dat <= '0;
    end else begin
      if (w_idle && bus.burst_start_i) r_addr <= bus.burst_address_i;
      r_rd_vld <= w_cpu_re;
      if (w_cpu_re) r_rd_dat <= w_rd_word;
      r_wb_vld <= (r_state == WRITEBACK);
      if (r_state == WRITEBACK) r_wb_dat <= w_wb_word;
    end
  end

  // Array is never cleared; writes are suppressed during a reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && w_cpu_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.port0_byte_write_i[b]) begin
          r_mem[{bus.port0_address_i, bus.port0_bank_i}][b*8 +: 8] <= bus.port0_data_i[b*8 +: 8];
        end
      end
    end
    if (rst_n_i && w_fill_we) begin
      r_mem[{r_addr, r_cnt}] <= bus.burst_data_i;
    end
  end

  assign bus.port1_data_o       = r_rd_dat;
  assign bus.port1_valid_o      = r_rd_vld;
  assign bus.burst_data_o       = r_wb_dat;
  assign bus.burst_data_valid_o = r_wb_vld;
  assign bus.burst_busy_o       = (r_state != IDLE);
  assign bus.burst_done_o       = r_done;
endmodule

// File: tb/tb_banked_cache_block.sv
// Scoreboard bench for banked_cache_block: directed scenarios then random CPU/burst traffic
// checked against a word-array reference model.
module tb_banked_cache_block;
  localparam int WW    = 32;
  localparam int BANKS = 4;
  localparam int DEPTH = 256;
  localparam int BYTES = WW / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BANKS);

  typedef logic [WW-1:0] word_t;
  typedef struct {
    word_t dat;
    bit    last;
  } wb_exp_t;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;

  banked_cache_block_if #(.WORD_WIDTH(WW), .BANKS(BANKS), .DEPTH(DEPTH)) bus ();

  banked_cache_block #(.WORD_WIDTH(WW), .BANKS(BANKS), .DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int      checks = 0;
  int      errors = 0;
  word_t   model [DEPTH][BANKS];
  word_t   rd_q [$];
  wb_exp_t wb_q [$];
  int      busy_run = 0;
  int      last_busy_run = 0;
  int      done_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clk_i) begin
    wb_exp_t e;
    if (bus.port1_valid_o) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_spurious: port1_valid_o=1 data 0x%0h, want no response", bus.port1_data_o);
      end else begin
        check("rd_data", bus.port1_data_o, rd_q.pop_front());
      end
    end
    if (bus.burst_data_valid_o) begin
      if (wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_spurious: burst_data_valid_o=1 data 0x%0h, want none", bus.burst_data_o);
      end else begin
        e = wb_q.pop_front();
        check("wb_data", bus.burst_data_o, e.dat);
        check("wb_done_align", bus.burst_done_o, e.last);
      end
    end
    if (bus.burst_busy_o) busy_run++;
    else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run = 0;
    end
    if (bus.burst_done_o) done_total++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_req();
    bus.port0_write_i      = 1'b0;
    bus.port1_read_i       = 1'b0;
    bus.burst_start_i      = 1'b0;
    bus.burst_data_valid_i = 1'b0;
  endtask

  task automatic model_write(input int a, input int k, input logic [BYTES-1:0] m, input word_t d);
    for (int b = 0; b < BYTES; b++) begin
      if (m[b]) model[a][k][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic cpu(input bit wr, input int wa, input int wk, input logic [BYTES-1:0] m,
                     input word_t d, input bit rd, input int ra, input int rk);
    bus.port0_write_i      = wr;
    bus.port0_address_i    = AW'(wa);
    bus.port0_bank_i       = BW'(wk);
    bus.port0_byte_write_i = m;
    bus.port0_data_i       = d;
    bus.port1_read_i       = rd;
    bus.port1_address_i    = AW'(ra);
    bus.port1_bank_i       = BW'(rk);
    if (wr) model_write(wa, wk, m, d);
    if (rd) rd_q.push_back(model[ra][rk]);
    step();
    clear_req();
  endtask

  task automatic refill(input int a, input word_t w [BANKS], input int stall_after);
    int d0 = done_total;
    int stalls = 0;
    bus.burst_start_i   = 1'b1;
    bus.burst_refill_i  = 1'b1;
    bus.burst_address_i = AW'(a);
    step();
    clear_req();
    for (int i = 0; i < BANKS; i++) begin
      bus.burst_data_valid_i = 1'b1;
      bus.burst_data_i       = w[i];
      model[a][i]            = w[i];
      step();
      clear_req();
      if (i == stall_after && i < BANKS - 1) begin
        bus.burst_data_i = ~w[i];
        stalls++;
        step();
      end
    end
    check("refill_done_pulse", bus.burst_done_o, 1'b1);
    check("refill_idle_after", bus.burst_busy_o, 1'b0);
    step();
    step();
    check("refill_done_once", done_total - d0, 1);
    check("refill_busy_len", last_busy_run, BANKS + stalls);
  endtask

  task automatic writeback(input int a, input bit inject);
    int d0 = done_total;
    for (int i = 0; i < BANKS; i++) wb_q.push_back('{dat: model[a][i], last: (i == BANKS - 1)});
    bus.burst_start_i   = 1'b1;
    bus.burst_refill_i  = 1'b0;
    bus.burst_address_i = AW'(a);
    step();
    clear_req();
    for (int c = 0; c < BANKS + 1; c++) begin
      if (inject && c == 1) begin
        // Dropped while busy: the model is deliberately left untouched.
        bus.port0_write_i      = 1'b1;
        bus.port0_address_i    = AW'(a);
        bus.port0_bank_i       = '0;
        bus.port0_byte_write_i = '1;
        bus.port0_data_i       = 32'hBAD0BAD0;
        bus.port1_read_i       = 1'b1;
        bus.port1_address_i    = AW'(a);
        bus.port1_bank_i       = '0;
        bus.burst_start_i      = 1'b1;
        bus.burst_refill_i     = 1'b1;
        bus.burst_address_i    = AW'((a + 1) % 16);
      end
      step();
      clear_req();
    end
    step();
    step();
    check("wb_done_once", done_total - d0, 1);
    check("wb_busy_len", last_busy_run, BANKS + 1);
    check("wb_q_empty", wb_q.size(), 0);
  endtask

  initial begin
    word_t w [BANKS];
    int    d0;

    clear_req();
    bus.burst_refill_i     = 1'b0;
    bus.port0_address_i    = '0;
    bus.port0_bank_i       = '0;
    bus.port0_byte_write_i = '0;
    bus.port0_data_i       = '0;
    bus.port1_address_i    = '0;
    bus.port1_bank_i       = '0;
    bus.burst_address_i    = '0;
    bus.burst_data_i       = '0;

    step();
    step();
    check("rst_port1_data", bus.port1_data_o, 0);
    check("rst_port1_valid", bus.port1_valid_o, 0);
    check("rst_burst_data", bus.burst_data_o, 0);
    check("rst_burst_valid", bus.burst_data_valid_o, 0);
    check("rst_busy", bus.burst_busy_o, 0);
    check("rst_done", bus.burst_done_o, 0);
    rst_n_i = 1'b1;
    step();

    for (int a = 0; a < 16; a++)
      for (int k = 0; k < BANKS; k++) cpu(1, a, k, '1, $urandom, 0, 0, 0);

    // Write then read, latency and hold behaviour.
    cpu(1, 5, 2, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    cpu(0, 0, 0, 4'h0, 32'h0, 1, 5, 2);
    check("t1_rd_valid", bus.port1_valid_o, 1'b1);
    check("t1_rd_data", bus.port1_data_o, 32'hDEADBEEF);
    step();
    check("t1_valid_drop", bus.port1_valid_o, 1'b0);
    check("t1_data_hold", bus.port1_data_o, 32'hDEADBEEF);

    // Same-cycle read-after-write forwarding.
    cpu(1, 5, 2, 4'b0010, 32'h0000AA00, 1, 5, 2);
    check("t2_fwd_data", bus.port1_data_o, 32'hDEADAAEF);

    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    refill(9, w, 1);
    for (int k = 0; k < BANKS; k++) cpu(0, 0, 0, 4'h0, 32'h0, 1, 9, k);
    step();

    writeback(9, 0);
    writeback(9, 1);
    cpu(0, 0, 0, 4'h0, 32'h0, 1, 9, 0);
    check("t5_dropped_write", bus.port1_data_o, 32'h11);

    // Reset in the middle of a refill of line 3.
    d0 = done_total;
    bus.burst_start_i   = 1'b1;
    bus.burst_refill_i  = 1'b1;
    bus.burst_address_i = AW'(3);
    step();
    clear_req();
    for (int i = 0; i < 2; i++) begin
      bus.burst_data_valid_i = 1'b1;
      bus.burst_data_i       = 32'hA5A50000 + 32'(i);
      model[3][i]            = 32'hA5A50000 + 32'(i);
      step();
      clear_req();
    end
    rst_n_i = 1'b0;
    step();
    check("t6_busy_after_rst", bus.burst_busy_o, 1'b0);
    check("t6_done_after_rst", bus.burst_done_o, 1'b0);
    rst_n_i = 1'b1;
    step();
    step();
    check("t6_no_done", done_total - d0, 0);
    for (int k = 0; k < BANKS; k++) cpu(0, 0, 0, 4'h0, 32'h0, 1, 3, k);

    // Random mixed traffic.
    for (int it = 0; it < 400; it++) begin
      int r = $urandom_range(0, 29);
      int a = $urandom_range(0, 15);
      if (r == 0) begin
        for (int i = 0; i < BANKS; i++) w[i] = $urandom;
        refill(a, w, int'($urandom_range(0, BANKS)) - 1);
      end else if (r == 1) begin
        writeback(a, 1'($urandom_range(0, 1)));
      end else begin
        int wk = $urandom_range(0, BANKS - 1);
        int ra = $urandom_range(0, 15);
        int rk = $urandom_range(0, BANKS - 1);
        if ($urandom_range(0, 2) == 0) begin
          ra = a;
          rk = wk;
        end
        cpu(1'($urandom_range(0, 1)), a, wk, BYTES'($urandom), $urandom,
            1'($urandom_range(0, 1)), ra, rk);
      end
    end

    step();
    step();
    check("final_rd_q_empty", rd_q.size(), 0);
    check("final_wb_q_empty", wb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
